// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    localparam int FIFO_BW    = 4;
    localparam int FIFO_DEPTH = 8;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mux_n_1.sv
// depth:1 read mux selecting the head entry from the storage array.
module fifo_mux_n_1
    import fifo_pkg::*;
#(
    parameter int bw    = FIFO_BW,
    parameter int simd  = 1,
    parameter int depth = FIFO_DEPTH
) (
    input  logic [depth-1:0][bw*simd-1:0] data,
    input  logic [$clog2(depth)-1:0]      sel,
    output logic [bw*simd-1:0]            y
);

    always_comb begin
        y = data[sel];
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock first-word-fall-through FIFO with occupancy,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int bw        = FIFO_BW,
    parameter int simd      = 1,
    parameter int depth     = FIFO_DEPTH,
    parameter int af_margin = 2,
    parameter int ae_margin = 2
) (
    input  logic                       rd_clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [bw*simd-1:0]         in,
    input  logic                       rd,
    input  logic                       clr_err,
    output logic [bw*simd-1:0]         out,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_afull,
    output logic                       o_aempty,
    output logic [ptr_w(depth)-1:0]    o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;
    localparam int W  = bw * simd;
    localparam logic [PW-1:0] AF_LEVEL = PW'(depth - af_margin);
    localparam logic [PW-1:0] AE_LEVEL = PW'(ae_margin);

    if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
        $error("fifo_param: depth must be a power of 2 and at least 2");
    end
    if ((af_margin >= depth) || (ae_margin >= depth)) begin : g_bad_margin
        $error("fifo_param: af_margin and ae_margin must be below depth");
    end

    logic [depth-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;
    logic                    empty, full, wr_acc, rd_acc;
    logic [PW-1:0]           count;

    assign empty  = (rd_ptr_q == wr_ptr_q);
    assign full   = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign count  = wr_ptr_q - rd_ptr_q;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign wr_acc = wr && (!full || rd);
    assign rd_acc = rd && !empty;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q[AW-1:0]] = in;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // A new error in the same cycle as clr_err keeps its flag set.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (rd && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mux_n_1 #(
        .bw    (bw),
        .simd  (simd),
        .depth (depth)
    ) u_read_mux (
        .data (mem_q),
        .sel  (rd_ptr_q[AW-1:0]),
        .y    (out)
    );

    assign o_empty     = empty;
    assign o_full      = full;
    assign o_count     = count;
    assign o_afull     = (count >= AF_LEVEL);
    assign o_aempty    = (count <= AE_LEVEL);
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule
